// File: rtl/bridge_pkg.sv
// Shared types and default address map for the multi-channel CPU-to-peripheral bridge.
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bridge_state_e;

  localparam int DEF_N_SLV = 6;
  localparam int DEF_AW    = 32;

  // Slave i lives at [i*AW +: AW]: DRAM, DIG, LED, SW, BTN, spare.
  localparam logic [DEF_N_SLV*DEF_AW-1:0] DEF_BASE = {
    32'hFFFF_F100, 32'hFFFF_F078, 32'hFFFF_F070,
    32'hFFFF_F060, 32'hFFFF_F000, 32'h0000_0000
  };
  localparam logic [DEF_N_SLV*DEF_AW-1:0] DEF_MASK = {
    32'hFFFF_FF00, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
    32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_0000
  };

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
module bridge_addr_decode
  import bridge_pkg::*;
#(
  parameter int                    N_SLV    = DEF_N_SLV,
  parameter int                    AW       = DEF_AW,
  parameter logic [N_SLV*AW-1:0]   SLV_BASE = DEF_BASE,
  parameter logic [N_SLV*AW-1:0]   SLV_MASK = DEF_MASK
) (
  input  logic [AW-1:0]    addr_i,
  output logic [N_SLV-1:0] sel_o,
  output logic             hit_o
);

  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (!hit_o && ((addr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
        sel_o[i] = 1'b1;
        hit_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_bridge_mc.sv
// CPU-to-peripheral bridge: decodes one CPU request onto N_SLV slave channels with
// per-slave wait states, byte strobes, bus timeout and decode-error reporting.
module bus_bridge_mc
  import bridge_pkg::*;
#(
  parameter int                    N_SLV    = DEF_N_SLV,
  parameter int                    AW       = DEF_AW,
  parameter int                    DW       = 32,
  parameter logic [N_SLV*AW-1:0]   SLV_BASE = DEF_BASE,
  parameter logic [N_SLV*AW-1:0]   SLV_MASK = DEF_MASK,
  parameter int                    TIMEOUT  = 255
) (
  input  logic                cpu_clk,
  input  logic                fpga_rstn,
  input  logic                m_req,
  input  logic                m_we,
  input  logic [AW-1:0]       m_addr,
  input  logic [DW-1:0]       m_wdata,
  input  logic [DW/8-1:0]     m_wstrb,
  output logic                m_ready,
  output logic [DW-1:0]       m_rdata,
  output logic                m_err,
  output logic [N_SLV-1:0]    s_sel,
  output logic                s_we,
  output logic [AW-1:0]       s_addr,
  output logic [DW-1:0]       s_wdata,
  output logic [DW/8-1:0]     s_wstrb,
  input  logic [N_SLV-1:0]    s_ready,
  input  logic [N_SLV*DW-1:0] s_rdata,
  output logic [AW-1:0]       err_addr,
  output logic [7:0]          err_cnt,
  output logic [1:0]          dbg_state
);

  // Handshake: the CPU holds m_req level-high until it sees the one-cycle m_ready pulse;
  // a slave completes by raising s_ready[i] while s_sel[i] is high, and nothing else counts.

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  bridge_state_e     state_q;
  logic              m_ready_q, m_err_q, s_we_q;
  logic [DW-1:0]     m_rdata_q, s_wdata_q;
  logic [N_SLV-1:0]  s_sel_q;
  logic [AW-1:0]     s_addr_q, err_addr_q;
  logic [DW/8-1:0]   s_wstrb_q;
  logic [7:0]        err_cnt_q;
  logic [CW-1:0]     wait_cnt_q;

  logic [N_SLV-1:0]  dec_sel;
  logic              dec_hit;
  logic              sel_ready;
  logic              timeout_hit;
  logic [DW-1:0]     rd_mux;

  bridge_addr_decode #(
    .N_SLV    (N_SLV),
    .AW       (AW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr_i (m_addr),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  assign sel_ready   = |(s_ready & s_sel_q);
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CW'(TIMEOUT));

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (s_sel_q[i]) rd_mux = rd_mux | s_rdata[i*DW +: DW];
    end
  end

  always_ff @(posedge cpu_clk or negedge fpga_rstn) begin
    if (!fpga_rstn) begin
      state_q    <= ST_IDLE;
      m_ready_q  <= 1'b0;
      m_err_q    <= 1'b0;
      m_rdata_q  <= '0;
      s_sel_q    <= '0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (m_req) begin
            s_we_q     <= m_we;
            s_addr_q   <= m_addr;
            s_wdata_q  <= m_wdata;
            s_wstrb_q  <= m_we ? m_wstrb : '0;
            wait_cnt_q <= '0;
            if (dec_hit) begin
              s_sel_q <= dec_sel;
              state_q <= ST_ACCESS;
            end else begin
              state_q    <= ST_RESP;
              m_ready_q  <= 1'b1;
              m_err_q    <= 1'b1;
              m_rdata_q  <= '0;
              err_addr_q <= m_addr;
              err_cnt_q  <= sat_inc8(err_cnt_q);
            end
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            state_q   <= ST_RESP;
            m_ready_q <= 1'b1;
            m_rdata_q <= s_we_q ? '0 : rd_mux;
            s_sel_q   <= '0;
          end else if (timeout_hit) begin
            state_q    <= ST_RESP;
            m_ready_q  <= 1'b1;
            m_err_q    <= 1'b1;
            m_rdata_q  <= '0;
            s_sel_q    <= '0;
            err_addr_q <= s_addr_q;
            err_cnt_q  <= sat_inc8(err_cnt_q);
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        // The response cycle never samples m_req, so a held request is not re-accepted.
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_ready   = m_ready_q;
  assign m_err     = m_err_q;
  assign m_rdata   = m_rdata_q;
  assign s_sel     = s_sel_q;
  assign s_we      = s_we_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule
